tinyqv_irq_ctrl: RTL and testbench

//  Parametrised platform interrupt controller for the nibble-serial TinyQV core. Owns mie/mip bits
//  16+, a per-channel edge/level type CSR, input synchronisers, fixed-priority selection and the

---
 rtl/tinyqv_irq_ctrl_if.sv | 19 +
 rtl/tinyqv_irq_ctrl.sv | 145 ++++++++++++++
 tb/tb_tinyqv_irq_ctrl.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/tinyqv_irq_ctrl_if.sv
// Nibble-serial CSR bus between the TinyQV core CSR logic and the platform interrupt controller.
// The core drives the sub-cycle counter and the CSR request; the controller answers one read nibble per clk.
interface tinyqv_irq_ctrl_if;
  logic [2:0]  counter;
  logic [11:0] csr_addr;
  logic [1:0]  csr_op;
  logic [3:0]  csr_wdata;
  logic [3:0]  csr_rdata;

  modport master (
    output counter, csr_addr, csr_op, csr_wdata,
    input  csr_rdata
  );

  modport slave (
    input  counter, csr_addr, csr_op, csr_wdata,
    output csr_rdata
  );
endinterface

// File: rtl/tinyqv_irq_ctrl.sv
// Platform interrupt controller for TinyQV: owns mie/mip bits 16+, the custom mitype CSR,
// input synchronisers, fixed-priority selection and the latched mcause code.
module tinyqv_irq_ctrl #(
  parameter int                 NUM_IRQ     = 8,
  parameter int                 SYNC_STAGES = 2,
  parameter logic [NUM_IRQ-1:0] EDGE_RESET  = '1,
  parameter bit                 AUTO_CLEAR  = 1'b1
) (
  input  logic                clk,
  input  logic                rstn,
  tinyqv_irq_ctrl_if.slave    io_csr,
  input  logic [NUM_IRQ-1:0]  i_irq_in,
  input  logic                i_global_ie,
  input  logic                i_take_interrupt,
  output logic                o_interrupt_pending,
  output logic [4:0]          o_cause_code
);

  localparam logic [11:0] ADDR_MIE    = 12'h304;
  localparam logic [11:0] ADDR_MIP    = 12'h344;
  localparam logic [11:0] ADDR_MITYPE = 12'h7C0;

  typedef enum logic [1:0] {
    OP_NONE  = 2'b00,
    OP_WRITE = 2'b01,
    OP_SET   = 2'b10,
    OP_CLEAR = 2'b11
  } csr_op_e;

  logic [NUM_IRQ-1:0] r_mie;
  logic [NUM_IRQ-1:0] r_mitype;
  logic [NUM_IRQ-1:0] r_pend;
  logic [NUM_IRQ-1:0] r_irq_last;
  logic [4:0]         r_cause;

  logic [NUM_IRQ-1:0] w_irq_s;
  logic [NUM_IRQ-1:0] w_rise;
  logic [NUM_IRQ-1:0] w_mip;
  logic [NUM_IRQ-1:0] w_active;
  logic [NUM_IRQ-1:0] w_take_oh;
  logic [NUM_IRQ-1:0] w_mie_n;
  logic [NUM_IRQ-1:0] w_mitype_n;
  logic [NUM_IRQ-1:0] w_clr_csr;
  logic [NUM_IRQ-1:0] w_clr_take;
  logic [NUM_IRQ-1:0] w_clr;
  logic [4:0]         w_cause;
  logic [15:0]        w_rd16;
  logic               w_d;
  logic               w_take;
  csr_op_e            w_op;

  function automatic logic f_apply(input logic old_bit, input logic d, input csr_op_e op);
    unique case (op)
      OP_WRITE: f_apply = d;
      OP_SET:   f_apply = old_bit | d;
      OP_CLEAR: f_apply = old_bit & ~d;
      default:  f_apply = old_bit;
    endcase
  endfunction

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign w_irq_s = i_irq_in;
    end else begin : g_sync
      logic [NUM_IRQ-1:0] r_sync [SYNC_STAGES];
      always_ff @(posedge clk) begin
        if (!rstn) begin
          for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
        end else begin
          r_sync[0] <= i_irq_in;
          for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
        end
      end
      assign w_irq_s = r_sync[SYNC_STAGES-1];
    end
  endgenerate

  assign w_op      = csr_op_e'(io_csr.csr_op);
  assign w_rise    = w_irq_s & ~r_irq_last;
  assign w_mip     = (r_mitype & r_pend) | (~r_mitype & w_irq_s);
  assign w_active  = w_mip & r_mie;
  assign w_take_oh = w_active & ~(w_active - NUM_IRQ'(1));
  assign w_take    = i_take_interrupt && (io_csr.counter == 3'd0) && (|w_active);

  // Each channel bit is touched only while the counter selects its nibble (counter 4..7).
  always_comb begin
    w_mie_n    = r_mie;
    w_mitype_n = r_mitype;
    w_clr_csr  = '0;
    w_d        = 1'b0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (io_csr.counter[2] && (io_csr.counter[1:0] == 2'(i / 4))) begin
        w_d = io_csr.csr_wdata[2'(i % 4)];
        if (io_csr.csr_addr == ADDR_MIE)    w_mie_n[i]    = f_apply(r_mie[i], w_d, w_op);
        if (io_csr.csr_addr == ADDR_MITYPE) w_mitype_n[i] = f_apply(r_mitype[i], w_d, w_op);
        if ((io_csr.csr_addr == ADDR_MIP) &&
            (((w_op == OP_WRITE) && !w_d) || ((w_op == OP_CLEAR) && w_d)))
          w_clr_csr[i] = r_mitype[i];
      end
    end
  end

  // Walk from the top down so the lowest active index is the one left standing.
  always_comb begin
    w_cause = 5'd16;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (w_active[i]) w_cause = 5'd16 + 5'(i);
    end
  end

  assign w_clr_take = (w_take && AUTO_CLEAR) ? (w_take_oh & r_mitype) : '0;
  assign w_clr      = w_clr_csr | w_clr_take | (r_mitype & ~w_mitype_n);

  // A rising edge on an edge channel wins over any clear arriving in the same clk.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_mie      <= '0;
      r_mitype   <= EDGE_RESET;
      r_pend     <= '0;
      r_irq_last <= '0;
      r_cause    <= 5'd16;
    end else begin
      r_mie      <= w_mie_n;
      r_mitype   <= w_mitype_n;
      r_pend     <= (w_rise & r_mitype) | (r_pend & ~w_clr);
      r_irq_last <= w_irq_s;
      if (w_take) r_cause <= w_cause;
    end
  end

  always_comb begin
    w_rd16 = '0;
    unique case (io_csr.csr_addr)
      ADDR_MIE:    w_rd16[NUM_IRQ-1:0] = r_mie;
      ADDR_MIP:    w_rd16[NUM_IRQ-1:0] = w_mip;
      ADDR_MITYPE: w_rd16[NUM_IRQ-1:0] = r_mitype;
      default:     w_rd16 = '0;
    endcase
  end

  assign io_csr.csr_rdata     = io_csr.counter[2] ? w_rd16[{io_csr.counter[1:0], 2'b00} +: 4] : 4'h0;
  assign o_interrupt_pending  = i_global_ie && (|w_active);
  assign o_cause_code         = r_cause;

endmodule

// File: tb/tb_tinyqv_irq_ctrl.sv
// Directed scenarios followed by random traffic for tinyqv_irq_ctrl, checked against a
// nibble-level behavioural model that delays irq_in through a history queue.
module tb_tinyqv_irq_ctrl;

  localparam bit [11:0] MIE    = 12'h304;
  localparam bit [11:0] MIP    = 12'h344;
  localparam bit [11:0] MITYPE = 12'h7C0;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] irqIn;
  logic       globalIe;
  logic       takeInt;
  logic       intPend;
  logic [4:0] cause;

  always #5 clk = ~clk;

  tinyqv_irq_ctrl_if bus ();

  tinyqv_irq_ctrl #(
    .NUM_IRQ     (8),
    .SYNC_STAGES (2),
    .EDGE_RESET  (8'hFF),
    .AUTO_CLEAR  (1'b1)
  ) dut (
    .clk                 (clk),
    .rstn                (rstn),
    .io_csr              (bus),
    .i_irq_in            (irqIn),
    .i_global_ie         (globalIe),
    .i_take_interrupt    (takeInt),
    .o_interrupt_pending (intPend),
    .o_cause_code        (cause)
  );

  int compared   = 0;
  int mismatched = 0;

  int unsigned mMie, mPend, mType, mCause;
  bit [7:0]    hist[$];
  bit [2:0]    cnt = 3'd0;
  bit [7:0]    curIrq = 8'h00;
  bit          curGie = 1'b0;
  logic [3:0]  lastRdata;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned nibOp(input int unsigned oldN, input bit [3:0] d, input bit [1:0] op);
    case (op)
      2'b01:   return d;
      2'b10:   return oldN | d;
      2'b11:   return oldN & {28'h0, ~d};
      default: return oldN;
    endcase
  endfunction

  // Synchronised request is the sample taken two edges ago; "last" is one edge older.
  function automatic int unsigned modelMip();
    return ((mType & mPend) | (~mType & hist[1])) & 32'hFF;
  endfunction

  function automatic int unsigned modelRead(input bit [11:0] addr, input bit [2:0] c);
    int unsigned v;
    if (c < 3'd4) return 0;
    case (addr)
      MIE:     v = mMie;
      MIP:     v = modelMip();
      MITYPE:  v = mType;
      default: v = 0;
    endcase
    return (v >> (4 * (c - 3'd4))) & 32'hF;
  endfunction

  function automatic bit modelPend(input bit gie);
    return gie && ((modelMip() & mMie) != 0);
  endfunction

  task automatic modelStep(input bit rn, input bit [7:0] irq, input bit [11:0] addr,
                           input bit [1:0] op, input bit [3:0] wd, input bit take);
    int unsigned rise, act, clr, newType, sh;
    bit [3:0] nd;
    if (!rn) begin
      mMie = 0; mPend = 0; mType = 32'hFF; mCause = 16;
      hist = '{8'h00, 8'h00, 8'h00};
      return;
    end
    rise    = hist[1] & ~hist[2];
    act     = modelMip() & mMie;
    clr     = 0;
    newType = mType;
    nd      = ~wd;
    if (cnt >= 3'd4 && op != 2'b00) begin
      sh = 4 * (cnt - 3'd4);
      if (addr == MIE)
        mMie = ((mMie & ~(32'hF << sh)) | (nibOp((mMie >> sh) & 32'hF, wd, op) << sh)) & 32'hFF;
      if (addr == MITYPE)
        newType = ((mType & ~(32'hF << sh)) | (nibOp((mType >> sh) & 32'hF, wd, op) << sh)) & 32'hFF;
      if (addr == MIP) begin
        if (op == 2'b01) clr = {28'h0, nd} << sh;
        else if (op == 2'b11) clr = {28'h0, wd} << sh;
        clr = clr & mType & 32'hFF;
      end
    end
    clr = clr | (mType & ~newType);
    if (take && cnt == 3'd0 && act != 0) begin
      for (int i = 0; i < 8; i++) begin
        if (act[i]) begin
          mCause = 16 + i;
          if (mType[i]) clr = clr | (32'h1 << i);
          break;
        end
      end
    end
    mPend = ((rise & mType) | (mPend & ~clr)) & 32'hFF;
    mType = newType & 32'hFF;
    hist.push_front(irq);
    void'(hist.pop_back());
  endtask

  task automatic applyStimulus(input bit rn, input bit [7:0] irq, input bit [11:0] addr,
                               input bit [1:0] op, input bit [3:0] wd, input bit gie, input bit take);
    rstn          = rn;
    irqIn         = irq;
    bus.counter   = cnt;
    bus.csr_addr  = addr;
    bus.csr_op    = op;
    bus.csr_wdata = wd;
    globalIe      = gie;
    takeInt       = take;
    #2;
    lastRdata = bus.csr_rdata;
    checkOutput("rdata", {28'h0, bus.csr_rdata}, modelRead(addr, cnt));
    checkOutput("pending", {31'h0, intPend}, {31'h0, modelPend(gie)});
    @(posedge clk);
    modelStep(rn, irq, addr, op, wd, take);
    cnt++;
    #1;
    checkOutput("cause", {27'h0, cause}, mCause);
  endtask

  task automatic idle();
    applyStimulus(1'b1, curIrq, 12'h000, 2'b00, 4'h0, curGie, 1'b0);
  endtask

  task automatic waitCounter(input bit [2:0] c);
    while (cnt != c) idle();
  endtask

  task automatic csrOp(input bit [11:0] addr, input bit [1:0] op, input bit [31:0] data);
    waitCounter(3'd0);
    for (int k = 0; k < 8; k++)
      applyStimulus(1'b1, curIrq, addr, op, 4'(data >> (4 * k)), curGie, 1'b0);
  endtask

  task automatic peek(input bit [11:0] addr, input bit [2:0] nib);
    waitCounter(nib);
    applyStimulus(1'b1, curIrq, addr, 2'b00, 4'h0, curGie, 1'b0);
  endtask

  task automatic takeIrq();
    waitCounter(3'd0);
    applyStimulus(1'b1, curIrq, 12'h000, 2'b00, 4'h0, curGie, 1'b1);
  endtask

  initial begin
    bit [11:0] addrs [4];
    addrs = '{MIE, MIP, MITYPE, 12'h300};

    // Reset held two clks with every request high.
    rstn = 1'b0; irqIn = 8'hFF; globalIe = 1'b0; takeInt = 1'b0;
    bus.csr_addr = 12'h000; bus.csr_op = 2'b00; bus.csr_wdata = 4'h0;
    for (int k = 0; k < 2; k++) begin
      bus.counter = cnt;
      @(posedge clk);
      cnt++;
    end
    modelStep(1'b0, 8'h00, 12'h000, 2'b00, 4'h0, 1'b0);
    #1;
    checkOutput("t1_cause", {27'h0, cause}, 32'd16);
    checkOutput("t1_pending", {31'h0, intPend}, 32'd0);
    curIrq = 8'h00;
    peek(MIE, 3'd4);
    checkOutput("t1_mie", {28'h0, lastRdata}, 32'h0);
    peek(MIP, 3'd4);
    checkOutput("t1_mip", {28'h0, lastRdata}, 32'h0);

    // Edge channel 2: pulse, pending after three edges, taken with auto-clear.
    curGie = 1'b1;
    csrOp(MIE, 2'b01, 32'h000F0000);
    applyStimulus(1'b1, 8'h04, 12'h000, 2'b00, 4'h0, curGie, 1'b0);
    idle();
    checkOutput("t2_notyet", {31'h0, intPend}, 32'd0);
    idle();
    checkOutput("t2_pend", {31'h0, intPend}, 32'd1);
    takeIrq();
    checkOutput("t2_cause", {27'h0, cause}, 32'd18);
    checkOutput("t2_cleared", {31'h0, intPend}, 32'd0);

    // Simultaneous rises on channels 1 and 5: lowest index first.
    csrOp(MIE, 2'b01, 32'h00FF0000);
    applyStimulus(1'b1, 8'h22, 12'h000, 2'b00, 4'h0, curGie, 1'b0);
    idle();
    idle();
    takeIrq();
    checkOutput("t3_cause1", {27'h0, cause}, 32'd17);
    checkOutput("t3_still", {31'h0, intPend}, 32'd1);
    takeIrq();
    checkOutput("t3_cause2", {27'h0, cause}, 32'd21);
    checkOutput("t3_done", {31'h0, intPend}, 32'd0);

    // Level channel 0 tracks the source and ignores mip clears.
    csrOp(MITYPE, 2'b01, 32'h0);
    curIrq = 8'h01;
    idle();
    idle();
    peek(MIP, 3'd4);
    checkOutput("t4_mip", {28'h0, lastRdata}, 32'h1);
    csrOp(MIP, 2'b11, 32'hFFFFFFFF);
    peek(MIP, 3'd4);
    checkOutput("t4_mip_kept", {28'h0, lastRdata}, 32'h1);
    curIrq = 8'h00;
    idle();
    checkOutput("t4_hold", {31'h0, intPend}, 32'd1);
    idle();
    checkOutput("t4_drop", {31'h0, intPend}, 32'd0);
    csrOp(MITYPE, 2'b01, 32'h00FF0000);

    // Rise on channel 3 lands on the same edge as a mip clear of that bit.
    waitCounter(3'd2);
    curIrq = 8'h08;
    for (int k = 2; k < 8; k++)
      applyStimulus(1'b1, curIrq, MIP, (k >= 4) ? 2'b11 : 2'b00, (k == 4) ? 4'h8 : 4'h0, curGie, 1'b0);
    peek(MIP, 3'd4);
    checkOutput("t5_race", {28'h0, lastRdata}, 32'h8);
    takeIrq();
    checkOutput("t5_cause", {27'h0, cause}, 32'd19);
    curIrq = 8'h00;
    idle();
    idle();

    // Reset lands mid-way through a mie write.
    waitCounter(3'd4);
    applyStimulus(1'b1, curIrq, MIE, 2'b01, 4'hF, curGie, 1'b0);
    applyStimulus(1'b0, curIrq, MIE, 2'b01, 4'hF, curGie, 1'b0);
    applyStimulus(1'b1, curIrq, MIE, 2'b00, 4'h0, curGie, 1'b0);
    applyStimulus(1'b1, curIrq, MIE, 2'b00, 4'h0, curGie, 1'b0);
    peek(MIE, 3'd4);
    checkOutput("t6_mie4", {28'h0, lastRdata}, 32'h0);
    peek(MIE, 3'd5);
    checkOutput("t6_mie5", {28'h0, lastRdata}, 32'h0);
    checkOutput("t6_cause", {27'h0, cause}, 32'd16);

    for (int n = 0; n < 600; n++) begin
      bit rn;
      if ($urandom_range(0, 3) == 0) curIrq = curIrq ^ 8'(1 << $urandom_range(0, 7));
      curGie = ($urandom_range(0, 7) != 0);
      rn = ($urandom_range(0, 79) != 0);
      applyStimulus(rn, curIrq, addrs[$urandom_range(0, 3)], 2'($urandom_range(0, 3)),
                    4'($urandom_range(0, 15)), curGie, ($urandom_range(0, 2) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
